// File: rtl/wb_regfile_pkg.sv
// Shared writeback definitions: select encodings used by control logic and the
// register file, plus common widths.
package wb_regfile_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        WBSel_MEM     = 2'd0,
        WBSel_ALU     = 2'd1,
        WBSel_PCPLUS4 = 2'd2,
        WBSel_RSVD    = 2'd3
    } wb_sel_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// Writeback / operand-read bus between the pipeline and the register file.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
);

    wb_sel_e             wb_sel;
    logic [DWIDTH-1:0]   wb_mem_data;
    logic [DWIDTH-1:0]   wb_alu_data;
    logic [DWIDTH-1:0]   wb_pc_plus4;
    logic [AWIDTH-1:0]   wb_rd;
    logic                wb_regwen;
    logic [AWIDTH-1:0]   rs1_addr;
    logic [AWIDTH-1:0]   rs2_addr;
    logic [DWIDTH-1:0]   rs1_data;
    logic [DWIDTH-1:0]   rs2_data;
    logic [DWIDTH-1:0]   wb_data;
    logic [CNT_W-1:0]    wb_count;

    modport master (
        output wb_sel, wb_mem_data, wb_alu_data, wb_pc_plus4,
        output wb_rd, wb_regwen, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, wb_count
    );

    modport slave (
        input  wb_sel, wb_mem_data, wb_alu_data, wb_pc_plus4,
        input  wb_rd, wb_regwen, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, wb_count
    );

endinterface : wb_regfile_if

// File: rtl/wb_mux.sv
// Writeback source select; the reserved encoding falls back to the ALU result.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  wb_sel_e           sel,
    input  logic [DWIDTH-1:0] mem_data,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic [DWIDTH-1:0] pc_plus4,
    output logic [DWIDTH-1:0] wb_data
);

    always_comb begin
        wb_data = alu_data;
        case (sel)
            WBSel_MEM:     wb_data = mem_data;
            WBSel_PCPLUS4: wb_data = pc_plus4;
            default:       wb_data = alu_data;
        endcase
    end

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// Integer register file with write-to-read bypass and a committed-write counter.
// x0 is hardwired to zero; reads are combinational from the array.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);

    localparam int unsigned NREGS = 2 ** AWIDTH;

    logic [DWIDTH-1:0] regs_q [NREGS];
    logic [DWIDTH-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  wb_count_q;
    logic [CNT_W-1:0]  wb_count_d;
    logic [DWIDTH-1:0] wb_data_c;
    logic              commit_c;
    logic              byp1_c;
    logic              byp2_c;

    wb_mux #(
        .DWIDTH (DWIDTH)
    ) u_wb_mux (
        .sel      (bus.wb_sel),
        .mem_data (bus.wb_mem_data),
        .alu_data (bus.wb_alu_data),
        .pc_plus4 (bus.wb_pc_plus4),
        .wb_data  (wb_data_c)
    );

    // Writes to x0 are dropped and neither update the array nor the count.
    assign commit_c = bus.wb_regwen && (bus.wb_rd != '0);
    assign byp1_c   = commit_c && (bus.rs1_addr == bus.wb_rd);
    assign byp2_c   = commit_c && (bus.rs2_addr == bus.wb_rd);

    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (commit_c) begin
            regs_d[bus.wb_rd] = wb_data_c;
            wb_count_d        = wb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Bypass never applies to x0 since commit_c already excludes wb_rd == 0.
    assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                          byp1_c ? wb_data_c : regs_q[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                          byp2_c ? wb_data_c : regs_q[bus.rs2_addr];
    assign bus.wb_data  = wb_data_c;
    assign bus.wb_count = wb_count_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected outputs are queued per step and
// popped against the DUT mid-cycle.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    sb_entry_t sb[$];

    wb_regfile_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

    wb_regfile #(
        .DWIDTH (32),
        .AWIDTH (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input wb_sel_e sel, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        bus.wb_sel      = sel;
        bus.wb_mem_data = mem;
        bus.wb_alu_data = alu;
        bus.wb_pc_plus4 = pc;
        bus.wb_rd       = rd;
        bus.wb_regwen   = wen;
        bus.rs1_addr    = a1;
        bus.rs2_addr    = a2;
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        sb_entry_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Queue the four expected outputs for this step, then sample 1ns later.
    task automatic expect4(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] wd, input logic [31:0] cnt);
        sb.push_back('{{tag, ".rs1"}, r1});
        sb.push_back('{{tag, ".rs2"}, r2});
        sb.push_back('{{tag, ".wbd"}, wd});
        sb.push_back('{{tag, ".cnt"}, cnt});
        #1;
        pop_chk(bus.rs1_data);
        pop_chk(bus.rs2_data);
        pop_chk(bus.wb_data);
        pop_chk(bus.wb_count);
    endtask

    initial begin
        bus.wb_sel      = WBSel_MEM;
        bus.wb_mem_data = '0;
        bus.wb_alu_data = '0;
        bus.wb_pc_plus4 = '0;
        bus.wb_rd       = '0;
        bus.wb_regwen   = 1'b0;
        bus.rs1_addr    = 5'd5;
        bus.rs2_addr    = 5'd31;
        repeat (2) @(posedge clk);

        drive(WBSel_MEM, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd5, 5'd31);
        rst = 1'b0;
        expect4("reset_read", 32'h0, 32'h0, 32'h0, 32'd0);

        drive(WBSel_PCPLUS4, 32'h0, 32'h0, 32'h104, 5'd1, 1'b1, 5'd1, 5'd0);
        expect4("pc4_bypass", 32'h104, 32'h0, 32'h104, 32'd0);
        drive(WBSel_PCPLUS4, 32'h0, 32'h0, 32'h104, 5'd1, 1'b0, 5'd1, 5'd0);
        expect4("pc4_array", 32'h104, 32'h0, 32'h104, 32'd1);

        drive(WBSel_MEM, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b1, 5'd0, 5'd0);
        expect4("x0_write_pre", 32'h0, 32'h0, 32'hDEAD_BEEF, 32'd1);
        drive(WBSel_MEM, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0);
        expect4("x0_write_post", 32'h0, 32'h0, 32'hDEAD_BEEF, 32'd1);

        drive(WBSel_ALU, 32'h0, 32'h55, 32'h0, 5'd7, 1'b1, 5'd7, 5'd7);
        expect4("dual_bypass", 32'h55, 32'h55, 32'h55, 32'd1);
        drive(WBSel_ALU, 32'h0, 32'h66, 32'h0, 5'd7, 1'b0, 5'd7, 5'd7);
        expect4("no_wen_no_bypass", 32'h55, 32'h55, 32'h66, 32'd2);

        drive(WBSel_RSVD, 32'h1, 32'h77, 32'h2, 5'd9, 1'b1, 5'd9, 5'd7);
        expect4("rsvd_sel_alu", 32'h77, 32'h55, 32'h77, 32'd2);
        drive(WBSel_ALU, 32'h0, 32'h99, 32'h0, 5'd1, 1'b1, 5'd7, 5'd1);
        expect4("rs2_only_bypass", 32'h55, 32'h99, 32'h99, 32'd3);
        drive(WBSel_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd9, 5'd1);
        expect4("array_readback", 32'h77, 32'h99, 32'h0, 32'd4);

        // Backdoor-load the counter near its wrap point.
        dut.wb_count_q = 32'hFFFF_FFFE;
        drive(WBSel_ALU, 32'h0, 32'h11, 32'h0, 5'd2, 1'b1, 5'd2, 5'd0);
        expect4("cnt_preload", 32'h11, 32'h0, 32'h11, 32'hFFFF_FFFE);
        drive(WBSel_ALU, 32'h0, 32'h22, 32'h0, 5'd2, 1'b1, 5'd2, 5'd0);
        expect4("cnt_max", 32'h22, 32'h0, 32'h22, 32'hFFFF_FFFF);
        drive(WBSel_ALU, 32'h0, 32'h22, 32'h0, 5'd2, 1'b0, 5'd2, 5'd0);
        expect4("cnt_wrap", 32'h22, 32'h0, 32'h22, 32'h0);

        drive(WBSel_ALU, 32'h0, 32'hA5, 32'h0, 5'd3, 1'b1, 5'd3, 5'd9);
        expect4("x3_write", 32'hA5, 32'h77, 32'hA5, 32'd0);
        drive(WBSel_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd3, 5'd9);
        expect4("x3_read", 32'hA5, 32'h77, 32'h0, 32'd1);
        #1 rst = 1'b1;
        expect4("async_reset", 32'h0, 32'h0, 32'h0, 32'd0);

        drive(WBSel_ALU, 32'h0, 32'h1234, 32'h0, 5'd4, 1'b1, 5'd4, 5'd3);
        expect4("rst_bypass", 32'h1234, 32'h0, 32'h1234, 32'd0);
        drive(WBSel_ALU, 32'h0, 32'h1234, 32'h0, 5'd4, 1'b1, 5'd4, 5'd0);
        expect4("rst_no_commit", 32'h1234, 32'h0, 32'h1234, 32'd0);
        #1 rst = 1'b0;
        expect4("rst_release_mid", 32'h1234, 32'h0, 32'h1234, 32'd0);
        drive(WBSel_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd4, 5'd3);
        expect4("first_commit", 32'h1234, 32'h0, 32'h0, 32'd1);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DWIDTH, default 32: data width of every register and data port.
REQ-002 Parameter AWIDTH, default 5: register address width; 2**AWIDTH registers.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wb_sel  in  2  writeback source: 0 = MEM, 1 = ALU, 2 = PC+4, 3 = reserved.
REQ-007 wb_mem_data  in  DWIDTH  load-extender result.
REQ-008 wb_alu_data  in  DWIDTH  ALU result.
REQ-009 wb_pc_plus4  in  DWIDTH  address of the next instruction.
REQ-010 wb_rd  in  AWIDTH  destination register.
REQ-011 wb_regwen  in  1  write enable from control logic.
REQ-012 rs1_addr, rs2_addr  in  AWIDTH each  decode-stage read addresses.
REQ-013 rs1_data, rs2_data  out  DWIDTH each  read data, including bypass.
REQ-014 wb_data  out  DWIDTH  selected writeback value, combinational.
REQ-015 wb_count  out  32  number of committed register writes.

Function
REQ-016 wb_data SHALL equal mem/alu/pc_plus4 data for wb_sel 0/1/2, and alu data for wb_sel 3.
REQ-017 A commit SHALL occur on a rising clk edge when wb_regwen=1 and wb_rd!=0; wb_data is written to register wb_rd.
REQ-018 Writes with wb_rd=0 SHALL be discarded; register 0 SHALL always read 0.
REQ-019 Reads SHALL be combinational (zero latency) from the register array.
REQ-020 Bypass: if wb_regwen=1, wb_rd!=0 and rsN_addr==wb_rd in the same cycle, rsN_data SHALL equal wb_data instead of the stored value.
REQ-021 Bypass SHALL apply to rs1 and rs2 independently; both SHALL be bypassed when both match.
REQ-022 rsN_addr=0 SHALL return 0 even when wb_rd=0 and wb_regwen=1.
REQ-023 wb_count SHALL increment by 1 on every commit (REQ-017) and hold otherwise.
REQ-024 wb_count SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-025 Discarded writes (wb_regwen=0 or wb_rd=0) SHALL NOT increment wb_count.
REQ-026 A value written at edge N SHALL be visible from the array in the cycle after edge N.

Reset
REQ-027 Asserting rst SHALL immediately clear all registers and wb_count to 0, regardless of clk.
REQ-028 While rst=1, no commit SHALL occur; rsN_data SHALL read 0 except when bypass (REQ-020) forwards wb_data.
REQ-029 If rst deasserts mid-cycle, the first commit SHALL be at the next rising edge with rst=0.

Structure
REQ-030 The wb_sel encodings (WBSel_MEM=0, WBSel_ALU=1, WBSel_PCPLUS4=2) SHALL come from the shared control-logic select header; they SHALL NOT be redefined locally.
REQ-031 The source mux SHALL be a sub-module wb_mux.
REQ-032 The array, bypass and counter SHALL remain in wb_regfile.

Verification
REQ-033 Scenario: reset, then read rs1=5, rs2=31. Required response: both read 0; wb_count=0.
REQ-034 Scenario: wb_sel=2, pc_plus4=0x104, rd=1, regwen=1. Required response: rs1_addr=1 returns 0x104 in the same cycle (bypass) and the next cycle (array); wb_count=1.
REQ-035 Scenario: wb_sel=0, mem=0xDEADBEEF, rd=0, regwen=1. Required response: rs1_addr=0 returns 0 before and after the edge; wb_count unchanged.
REQ-036 Scenario: rs1=rs2=7, wb_sel=1, alu=0x55, rd=7, regwen=1. Required response: both outputs return 0x55 in the same cycle.
REQ-037 Scenario: force wb_count=0xFFFFFFFF via 2**32-1 commits (or backdoor load), then commit once. Required response: wb_count=0.
REQ-038 Scenario: write x3=0xA5, then assert rst asynchronously between edges. Required response: rs_addr=3 reads 0 before the next edge; wb_count=0.
